// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one uart_tx among NUM_REQ byte producers.
//
// state | meaning
// IDLE  | no transfer owned; arbitrate when any req_i is set and tx_busy_i is low
// ARM   | byte latched, tx_e_o pulsed; waiting for tx_busy_i to rise (bounded)
// SEND  | frame in progress; waiting for tx_busy_i to fall
// GAP   | optional idle spacing before the next arbitration
module uart_tx_arb #(
  parameter int NUM_REQ     = 4,
  parameter int ARM_TIMEOUT = 16,
  parameter int GAP_CLKS    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*8-1:0] d_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 tx_e_o,
  output logic [7:0]           tx_d_o,
  input  logic                 tx_busy_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int PW      = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);
  localparam int IW      = PW + 1;
  localparam int CNT_MAX = (ARM_TIMEOUT > GAP_CLKS) ? ARM_TIMEOUT : GAP_CLKS;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CW-1:0]      ARM_LOAD = CW'(ARM_TIMEOUT - 1);
  localparam logic [CW-1:0]      GAP_LOAD = CW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [PW-1:0]      PTR_RST  = PW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SEND, ST_GAP} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [7:0]           tx_d_q, tx_d_d;
  logic                 tx_e_q, tx_e_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  logic                 win_found;
  logic [PW-1:0]        win_idx;
  logic [IW-1:0]        rr_idx;
  logic [7:0]           win_byte;

  // Round-robin search: first set request strictly after the last winner, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_idx = {1'b0, ptr_q} + IW'(i);
      if (rr_idx >= IW'(NUM_REQ)) rr_idx = rr_idx - IW'(NUM_REQ);
      if (!win_found && req_i[rr_idx[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_idx[PW-1:0];
      end
    end
    win_byte = d_i[{win_idx, 3'b000} +: 8];
  end

  // Sequencer next-state; pulses default low so they last exactly one cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    tx_d_d  = tx_d_q;
    tx_e_d  = 1'b0;
    ack_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found && !tx_busy_i) begin
          tx_d_d  = win_byte;
          tx_e_d  = 1'b1;
          ack_d   = ONE << win_idx;
          grant_d = ONE << win_idx;
          ptr_d   = win_idx;
          cnt_d   = ARM_LOAD;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (tx_busy_i) begin
          state_d = ST_SEND;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SEND: begin
        if (!tx_busy_i) begin
          grant_d = '0;
          if (GAP_CLKS == 0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = GAP_LOAD;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      tx_d_q  <= 8'h00;
      tx_e_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      tx_d_q  <= tx_d_d;
      tx_e_q  <= tx_e_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign ack_o   = ack_q;
  assign grant_o = grant_q;
  assign tx_e_o  = tx_e_q;
  assign tx_d_o  = tx_d_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: one instance without gap, one with GAP_CLKS=5, sharing stimulus.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_i;
  logic [31:0] d_i;
  logic        tx_busy_i;

  logic [3:0]  ack_o, grant_o;
  logic        tx_e_o, busy_o, err_o;
  logic [7:0]  tx_d_o;

  logic [3:0]  g_ack_o, g_grant_o;
  logic        g_tx_e_o, g_busy_o, g_err_o;
  logic [7:0]  g_tx_d_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(.NUM_REQ(4), .ARM_TIMEOUT(16), .GAP_CLKS(0)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .d_i(d_i),
    .ack_o(ack_o), .grant_o(grant_o), .tx_e_o(tx_e_o), .tx_d_o(tx_d_o),
    .tx_busy_i(tx_busy_i), .busy_o(busy_o), .err_o(err_o)
  );

  uart_tx_arb #(.NUM_REQ(4), .ARM_TIMEOUT(16), .GAP_CLKS(5)) dut_gap (
    .clk(clk), .reset(reset), .req_i(req_i), .d_i(d_i),
    .ack_o(g_ack_o), .grant_o(g_grant_o), .tx_e_o(g_tx_e_o), .tx_d_o(g_tx_d_o),
    .tx_busy_i(tx_busy_i), .busy_o(g_busy_o), .err_o(g_err_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    reset = 1'b1; req_i = '0; d_i = '0; tx_busy_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_start(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (tx_e_o === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic finish_frame();
    tx_busy_i = 1'b1;
    repeat (3) @(negedge clk);
    tx_busy_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_i = 4'hF; d_i = 32'hDEADBEEF; tx_busy_i = 1'b0;
    @(negedge clk);
    n_checks++; if ({ack_o, grant_o, tx_e_o, tx_d_o, busy_o, err_o} !== 19'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {ack_o, grant_o, tx_e_o, tx_d_o, busy_o, err_o}); end
    n_checks++; if ({g_ack_o, g_grant_o, g_tx_e_o, g_tx_d_o, g_busy_o, g_err_o} !== 19'd0) begin n_fail++; $display("FAIL reset_outputs_gap: got %h want 0", {g_ack_o, g_grant_o, g_tx_e_o, g_tx_d_o, g_busy_o, g_err_o}); end
    reset = 1'b0; req_i = '0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic seen;
    apply_reset();
    req_i = 4'b0001; d_i = 32'h0000_0041;
    wait_start(seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL basic_start: got %b want 1", seen); end
    n_checks++; if (tx_d_o !== 8'h41) begin n_fail++; $display("FAIL basic_tx_d: got %h want 41", tx_d_o); end
    n_checks++; if (ack_o !== 4'b0001) begin n_fail++; $display("FAIL basic_ack: got %b want 0001", ack_o); end
    n_checks++; if (grant_o !== 4'b0001) begin n_fail++; $display("FAIL basic_grant: got %b want 0001", grant_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy_arm: got %b want 1", busy_o); end
    req_i = '0;
    @(negedge clk);
    n_checks++; if ({tx_e_o, ack_o} !== 5'd0) begin n_fail++; $display("FAIL basic_pulse_width: got %b want 00000", {tx_e_o, ack_o}); end
    tx_busy_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({busy_o, grant_o, tx_d_o} !== {1'b1, 4'b0001, 8'h41}) begin n_fail++; $display("FAIL basic_send_hold: got %h want %h", {busy_o, grant_o, tx_d_o}, {1'b1, 4'b0001, 8'h41}); end
    tx_busy_i = 1'b0;
    @(negedge clk);
    n_checks++; if ({busy_o, grant_o} !== 5'd0) begin n_fail++; $display("FAIL basic_release: got %b want 00000", {busy_o, grant_o}); end
  endtask

  task automatic test_foreign_busy();
    int n_e;
    apply_reset();
    tx_busy_i = 1'b1; req_i = 4'b0100; d_i = 32'h00AB_0000;
    n_e = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_e_o === 1'b1) n_e++;
    end
    n_checks++; if (n_e != 0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL foreign_holdoff: got starts=%0d busy=%b want 0/0", n_e, busy_o); end
    tx_busy_i = 1'b0;
    @(negedge clk);
    n_checks++; if ({tx_e_o, ack_o, tx_d_o} !== {1'b1, 4'b0100, 8'hAB}) begin n_fail++; $display("FAIL foreign_start: got %h want %h", {tx_e_o, ack_o, tx_d_o}, {1'b1, 4'b0100, 8'hAB}); end
    req_i = '0;
    finish_frame();
  endtask

  task automatic test_round_robin();
    logic       seen;
    logic [7:0] exp_d;
    logic [3:0] exp_oh;
    apply_reset();
    req_i = 4'b1111; d_i = 32'h1312_1110;
    for (int k = 0; k < 5; k++) begin
      exp_d  = 8'h10 + 8'(k % 4);
      exp_oh = 4'b0001 << (k % 4);
      wait_start(seen);
      n_checks++; if ({seen, tx_d_o, ack_o, grant_o} !== {1'b1, exp_d, exp_oh, exp_oh}) begin n_fail++; $display("FAIL rr_frame%0d: got seen=%b d=%h ack=%b grant=%b want d=%h oh=%b", k, seen, tx_d_o, ack_o, grant_o, exp_d, exp_oh); end
      finish_frame();
    end
    req_i = '0;
  endtask

  task automatic test_late_req();
    logic       seen;
    logic [3:0] exp_oh;
    int         seq[4] = '{0, 1, 2, 0};
    apply_reset();
    req_i = 4'b0101; d_i = 32'hA3A2_A1A0;
    for (int k = 0; k < 4; k++) begin
      exp_oh = 4'b0001 << seq[k];
      wait_start(seen);
      n_checks++; if ({seen, grant_o, tx_d_o} !== {1'b1, exp_oh, 8'hA0 + 8'(seq[k])}) begin n_fail++; $display("FAIL late_req_frame%0d: got seen=%b grant=%b d=%h want grant=%b", k, seen, grant_o, tx_d_o, exp_oh); end
      if (k == 0) req_i = 4'b0111;
      finish_frame();
    end
    req_i = '0;
  endtask

  task automatic test_arm_timeout();
    logic       seen;
    int         err_at, err_cnt;
    logic [3:0] g_at;
    logic       b_at;
    apply_reset();
    req_i = 4'b0010; d_i = 32'h0000_5500;
    wait_start(seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL timeout_start: got %b want 1", seen); end
    req_i = '0;
    err_at = 0; err_cnt = 0; g_at = 4'hF; b_at = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (err_o === 1'b1) begin
        err_cnt++;
        if (err_at == 0) begin err_at = i; g_at = grant_o; b_at = busy_o; end
      end
    end
    n_checks++; if (err_at != 16) begin n_fail++; $display("FAIL timeout_delay: got %0d want 16", err_at); end
    n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL timeout_pulse: got %0d cycles want 1", err_cnt); end
    n_checks++; if ({g_at, b_at} !== 5'd0) begin n_fail++; $display("FAIL timeout_idle: got grant=%b busy=%b want 0000/0", g_at, b_at); end
    req_i = 4'b1000; d_i = 32'h7700_0000;
    wait_start(seen);
    n_checks++; if ({seen, grant_o, tx_d_o} !== {1'b1, 4'b1000, 8'h77}) begin n_fail++; $display("FAIL timeout_recover: got seen=%b grant=%b d=%h want 1/1000/77", seen, grant_o, tx_d_o); end
    req_i = '0;
    finish_frame();
  endtask

  task automatic test_gap();
    logic       seen;
    int         g_at, a_at;
    logic [3:0] g_grant1, g_ack;
    logic       g_busy1, a_busy1, g_busy6;
    logic [7:0] g_d;
    apply_reset();
    req_i = 4'b0011; d_i = 32'h0000_C1C0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (g_tx_e_o === 1'b1) seen = 1'b1;
    end
    n_checks++; if ({seen, g_tx_d_o, g_ack_o} !== {1'b1, 8'hC0, 4'b0001}) begin n_fail++; $display("FAIL gap_first: got seen=%b d=%h ack=%b want 1/C0/0001", seen, g_tx_d_o, g_ack_o); end
    req_i = 4'b0010;
    tx_busy_i = 1'b1;
    repeat (3) @(negedge clk);
    tx_busy_i = 1'b0;
    g_at = 0; a_at = 0; g_grant1 = 'x; g_busy1 = 'x; a_busy1 = 'x; g_busy6 = 'x; g_d = 'x; g_ack = 'x;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin g_grant1 = g_grant_o; g_busy1 = g_busy_o; a_busy1 = busy_o; end
      if (i == 6) g_busy6 = g_busy_o;
      if (g_tx_e_o === 1'b1 && g_at == 0) begin g_at = i; g_d = g_tx_d_o; g_ack = g_ack_o; end
      if (tx_e_o === 1'b1 && a_at == 0) a_at = i;
    end
    n_checks++; if (g_at != 7) begin n_fail++; $display("FAIL gap_spacing: got %0d want 7", g_at); end
    n_checks++; if (a_at != 2) begin n_fail++; $display("FAIL nogap_spacing: got %0d want 2", a_at); end
    n_checks++; if ({g_grant1, g_busy1} !== {4'b0000, 1'b1}) begin n_fail++; $display("FAIL gap_entry: got grant=%b busy=%b want 0000/1", g_grant1, g_busy1); end
    n_checks++; if ({a_busy1, g_busy6} !== 2'b00) begin n_fail++; $display("FAIL gap_idle_cycle: got nogap_busy=%b gap_busy=%b want 0/0", a_busy1, g_busy6); end
    n_checks++; if ({g_d, g_ack} !== {8'hC1, 4'b0010}) begin n_fail++; $display("FAIL gap_second: got d=%h ack=%b want C1/0010", g_d, g_ack); end
    req_i = '0;
  endtask

  task automatic test_reset_mid();
    logic seen;
    apply_reset();
    req_i = 4'b0001; d_i = 32'h0000_005A;
    wait_start(seen);
    req_i = '0;
    tx_busy_i = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({seen, busy_o, grant_o} !== {1'b1, 1'b1, 4'b0001}) begin n_fail++; $display("FAIL rstmid_send: got seen=%b busy=%b grant=%b want 1/1/0001", seen, busy_o, grant_o); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({ack_o, grant_o, tx_e_o, tx_d_o, busy_o, err_o} !== 19'd0) begin n_fail++; $display("FAIL rstmid_async: got %h want 0", {ack_o, grant_o, tx_e_o, tx_d_o, busy_o, err_o}); end
    @(negedge clk);
    reset = 1'b0; tx_busy_i = 1'b0;
    req_i = 4'b1001; d_i = 32'h6400_0061;
    wait_start(seen);
    n_checks++; if ({seen, grant_o, tx_d_o} !== {1'b1, 4'b0001, 8'h61}) begin n_fail++; $display("FAIL rstmid_priority: got seen=%b grant=%b d=%h want 1/0001/61", seen, grant_o, tx_d_o); end
    req_i = '0;
    finish_frame();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_foreign_busy();
    test_round_robin();
    test_late_req();
    test_arm_timeout();
    test_gap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one uart_tx transmitter between NUM_REQ byte producers.
- Sits between the producers (echo path, status reporter, debug dump, etc.) and the uart_tx e_i/d_i/busy_o interface.
- Latches the winning requester's byte and pulses the transmitter enable.
- Waits for the frame to complete, optionally inserts an idle gap, then re-arbitrates.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ARM_TIMEOUT, 16, clocks to wait for tx_busy_i to rise after tx_e_o before abandoning the byte.
- GAP_CLKS, 0, idle clocks inserted after tx_busy_i falls, before the next grant; 0 means no gap.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester level request; bit n high means d_i[8n+7:8n] is valid.
- d_i  input  NUM_REQ*8  flattened request bytes; requester n owns bits [8n+7:8n].
- ack_o  output  NUM_REQ  one-cycle pulse; bit n means requester n's byte was accepted.
- grant_o  output  NUM_REQ  one-hot owner of the current transfer; all zero when idle.
- tx_e_o  output  1  one-cycle start pulse to uart_tx e_i.
- tx_d_o  output  8  registered byte to uart_tx d_i; held stable for the whole transfer.
- tx_busy_i  input  1  uart_tx busy_o.
- busy_o  output  1  high in every state except IDLE.
- err_o  output  1  one-cycle pulse on ARM timeout.

Behaviour:
- Reset values:
  - All outputs 0; tx_d_o = 8'h00.
  - State = IDLE.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Counters = 0.
- Reset asserted mid-transfer: return to the reset values immediately; no ack and no err. The byte in flight in uart_tx is not tracked.
- IDLE:
  - If req_i != 0, pick the first set bit searching upward (with wrap) from pointer+1.
  - On the next edge (registered):
    - tx_d_o <= winner's byte.
    - tx_e_o = 1 and ack_o[winner] = 1 for exactly one cycle.
    - grant_o = onehot(winner); pointer <= winner.
    - Go to ARM.
  - Latency: req_i sampled high at edge k gives tx_e_o/ack_o high during cycle k+1.
- ARM:
  - Count clocks. If tx_busy_i = 1, go to SEND.
  - If the count reaches ARM_TIMEOUT with tx_busy_i still 0:
    - pulse err_o for one cycle;
    - clear grant_o;
    - go to IDLE (byte dropped; ack was already given);
    - the pointer still advances.
- SEND: hold grant_o and tx_d_o. When tx_busy_i = 0:
  - if GAP_CLKS = 0, go to IDLE;
  - otherwise go to GAP.
- GAP: count GAP_CLKS clocks, then go to IDLE. grant_o is cleared on entry to GAP.
- Request handling:
  - req_i and d_i are ignored outside IDLE.
  - A requester must keep req_i and its byte stable until ack_o.
  - A requester that holds req_i high after ack is re-served only after the others get their turn.
- Simultaneous requests: exactly one ack per arbitration; never two ack_o bits high in the same cycle.
- Back-to-back, GAP_CLKS = 0: at least one IDLE cycle separates tx_busy_i falling and the next tx_e_o.
- Single active requester: served repeatedly; the pointer wrap is transparent.
- tx_busy_i already high in IDLE (foreign activity): arbitration is held off until tx_busy_i = 0.
- Invariants:
  - tx_e_o is never high outside the IDLE-to-ARM transition cycle.
  - grant_o is zero or one-hot.

Test Plan:
- Reset, then req_i = 4'b0001 with d_i[7:0] = 8'h41 → tx_e_o and ack_o[0] pulse one cycle later; tx_d_o = 8'h41; grant_o = 4'b0001; busy_o stays high until tx_busy_i falls. With a real uart_tx, the line shows 0x41.
- req_i = 4'b1111 held continuously, bytes 8'h10/8'h11/8'h12/8'h13 → transmit order 10, 11, 12, 13, 10, …; one ack per frame; no double acks.
- req_i = 4'b0101 held, then 4'b0010 asserted mid-transfer of requester 0 → next grants are 1, then 2, then 0.
- tx_busy_i tied 0 with ARM_TIMEOUT = 16 → err_o pulses exactly 16 clocks after tx_e_o; state returns to IDLE; the next request is served normally.
- GAP_CLKS = 5 with two queued requests → exactly 5 idle clocks after tx_busy_i falls, plus one IDLE cycle, before the second tx_e_o.
- Assert reset during SEND → all outputs 0 within the same cycle (asynchronous); after release, requester 0 has priority again.
